// File: rtl/pipelined_cla.sv
// Pipelined carry-lookahead adder: WIDTH bits split into STAGES segments, one segment per stage.
// Optional subtract mode (port sub) is enabled by defining CLA_SUB_EN.
module pipelined_cla #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;
  localparam int unsigned NG  = SEG / 4;

  if ((STAGES == 0) || ((WIDTH % (4 * STAGES)) != 0)) begin : g_bad_cfg
    $error("pipelined_cla: WIDTH must be divisible by 4*STAGES");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

`ifdef CLA_SUB_EN
  // Subtract is a + ~b + 1; the caller's carry-in is ignored in that mode.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | c0;
`else
  assign b_eff = b;
  assign c_eff = c0;
`endif

  // Sum-of-products lookahead: carry into position n from generate/propagate vectors and carry-in.
  function automatic logic carry_la(input logic [SEG-1:0] gv, input logic [SEG-1:0] pv,
                                    input logic ci, input int n);
    logic c;
    logic t;
    c = ci;
    for (int q = 0; q < int'(SEG); q++)
      if (q < n) c = c & pv[q];
    for (int m = 0; m < int'(SEG); m++) begin
      if (m < n) begin
        t = gv[m];
        for (int q = m + 1; q < int'(SEG); q++)
          if (q < n) t = t & pv[q];
        c = c | t;
      end
    end
    return c;
  endfunction

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stg
    // a_src/b_src hold the operand bits not yet consumed; bits [SEG-1:0] belong to this stage.
    localparam int unsigned OW = WIDTH - SEG * k;

    logic [OW-1:0]          a_src;
    logic [OW-1:0]          b_src;
    logic [(k+1)*SEG-1:0]   s_acc;
    logic                   ci;
    logic                   v_src;
    logic                   co;
    logic [SEG-1:0]         p;
    logic [SEG-1:0]         g;
    logic [SEG-1:0]         c;
    logic [SEG-1:0]         s;
    logic [NG-1:0]          gg;
    logic [NG-1:0]          gp;
    logic [NG:0]            cg;

    // Two-level lookahead: group P/G per nibble, then group carries, then bit carries.
    always_comb begin
      p  = a_src[SEG-1:0] ^ b_src[SEG-1:0];
      g  = a_src[SEG-1:0] & b_src[SEG-1:0];
      gg = '0;
      gp = '0;
      cg = '0;
      c  = '0;
      for (int j = 0; j < int'(NG); j++) begin
        gg[j] = carry_la(SEG'(g[4*j +: 4]), SEG'(p[4*j +: 4]), 1'b0, 4);
        gp[j] = &p[4*j +: 4];
      end
      for (int j = 0; j <= int'(NG); j++)
        cg[j] = carry_la(SEG'(gg), SEG'(gp), ci, j);
      for (int i = 0; i < int'(SEG); i++)
        c[i] = carry_la(SEG'(g[4*(i/4) +: 4]), SEG'(p[4*(i/4) +: 4]), cg[i/4], i % 4);
      s = p ^ c;
    end

    assign co = cg[NG];

    if (k == 0) begin : g_first
      assign a_src = a;
      assign b_src = b_eff;
      assign ci    = c_eff;
      assign v_src = in_valid;
      assign s_acc = s;
    end else begin : g_next
      localparam int unsigned PW = WIDTH - SEG * (k - 1);

      logic [OW-1:0]      a_q;
      logic [OW-1:0]      b_q;
      logic [k*SEG-1:0]   s_q;
      logic               c_q;
      logic               v_q;

      // Inter-stage register: remaining operands, finished low sum bits, segment carry, valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (advance) begin
          a_q <= g_stg[k-1].a_src[PW-1:SEG];
          b_q <= g_stg[k-1].b_src[PW-1:SEG];
          s_q <= g_stg[k-1].s_acc;
          c_q <= g_stg[k-1].co;
          v_q <= g_stg[k-1].v_src;
        end
      end

      assign a_src = a_q;
      assign b_src = b_q;
      assign ci    = c_q;
      assign v_src = v_q;
      assign s_acc = {s, s_q};
    end
  end

  // Output register closes the last stage; it holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= g_stg[STAGES-1].v_src;
      sum       <= g_stg[STAGES-1].s_acc;
      cout      <= g_stg[STAGES-1].co;
      ovf       <= g_stg[STAGES-1].c[SEG-1] ^ g_stg[STAGES-1].co;
    end
  end

endmodule

// File: tb/tb_pipelined_cla.sv
// Self-checking bench for pipelined_cla: directed table, stall/reset sequences, random scoreboard,
// and 16-bit builds with one and four stages.
module tb_pipelined_cla;

  localparam int unsigned W = 32;
  localparam int unsigned S = 2;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c0;
    logic         sb;
    logic [W-1:0] s;
    logic         co;
    logic         of;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c0;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic         v16;
  logic         r16;
  logic [15:0]  a16;
  logic [15:0]  b16;
  logic         c016;
  logic         ir1;
  logic         ir4;
  logic         ov1;
  logic         ov4;
  logic [15:0]  s1;
  logic [15:0]  s4;
  logic         co1;
  logic         co4;
  logic         of1;
  logic         of4;

  int           errors = 0;
  int           checks = 0;
  int           ndeliv = 0;
  logic [W+1:0] q[$];
  logic [W-1:0] got[$];
  vec_t         tbl[$];
  logic [17:0]  e16[40];

  always #5 clk = ~clk;

  pipelined_cla #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c0(c0),
`ifdef CLA_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_cla #(.WIDTH(16), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir1),
    .a(a16), .b(b16), .c0(c016),
`ifdef CLA_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(ov1), .out_ready(r16), .sum(s1), .cout(co1), .ovf(of1)
  );

  pipelined_cla #(.WIDTH(16), .STAGES(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir4),
    .a(a16), .b(b16), .c0(c016),
`ifdef CLA_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(ov4), .out_ready(r16), .sum(s4), .cout(co4), .ovf(of4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic         of;
    yy   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + (W+1)'(sb ? 1'b1 : ci);
    of   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {of, full};
  endfunction

  function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [16:0] full;
    full = {1'b0, x} + {1'b0, y} + 17'(ci);
    return {(x[15] == y[15]) && (full[15] != x[15]), full};
  endfunction

  function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                              input logic sb, input logic [W-1:0] s, input logic co, input logic of);
    vec_t v;
    v.a = x; v.b = y; v.c0 = ci; v.sb = sb; v.s = s; v.co = co; v.of = of;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard on the main DUT: handshakes are evaluated half a cycle before the edge that fires them.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        got.push_back(sum);
        ndeliv++;
        if (q.size() == 0) chk("sb_unexpected", 64'(sum), 64'hDEAD_BEEF_0000_0000);
        else chk("sb_result", 64'({ovf, cout, sum}), 64'(q.pop_front()));
      end
      if (in_valid && in_ready) q.push_back(model(a, b, c0, sub));
    end
  end

  task automatic run_vec(input vec_t v, input string name);
    a = v.a; b = v.b; c0 = v.c0; sub = v.sb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({name, "_rdy"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < int'(S); i++) begin
      chk({name, "_lat"}, 64'(out_valid), 64'd0);
      tick();
    end
    chk({name, "_vld"}, 64'(out_valid), 64'd1);
    chk(name, 64'({ovf, cout, sum}), 64'({v.of, v.co, v.s}));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c0 = 1'b0; sub = 1'b0; out_ready = 1'b0;
    v16 = 1'b0; r16 = 1'b0; a16 = '0; b16 = '0; c016 = 1'b0;

    tbl.push_back(mk(32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0));
    tbl.push_back(mk(32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1));
    tbl.push_back(mk(32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0));
    tbl.push_back(mk(32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0));
    tbl.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1));
    tbl.push_back(mk(32'h0000_FFFF, 32'h1,         1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0));
    tbl.push_back(mk(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 32'h9999_999A, 1'b0, 1'b0));
    tbl.push_back(mk(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0));
`ifdef CLA_SUB_EN
    tbl.push_back(mk(32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0));
    tbl.push_back(mk(32'd7,         32'd5,         1'b1, 1'b1, 32'h2,         1'b1, 1'b0));
`endif

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_data", 64'({ovf, cout, sum}), 64'd0);
    chk("rst_s1_valid", 64'(ov1), 64'd0);
    chk("rst_s4_valid", 64'({ov4, co4, s4}), 64'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back beats with a two-cycle output stall in the middle.
    got.delete();
    in_valid = 1'b1; out_ready = 1'b1; c0 = 1'b0; sub = 1'b0;
    a = 32'd1; b = 32'd1; tick();
    a = 32'd2; b = 32'd2; tick();
    out_ready = 1'b0; a = 32'd3; b = 32'd3;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_hold", 64'({out_valid, ovf, cout, sum}), 64'({1'b1, 1'b0, 1'b0, 32'd2}));
      if (i < 2) tick();
    end
    out_ready = 1'b1; tick();
    a = 32'd4; b = 32'd4; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stall_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size(); i++) chk("stall_order", 64'(got[i]), 64'(2 * (i + 1)));

    // Reset with two beats in flight.
    got.delete();
    in_valid = 1'b1; a = 32'd5; b = 32'd5; tick();
    a = 32'd6; b = 32'd6; tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstm_out_valid", 64'(out_valid), 64'd0);
    chk("rstm_in_ready", 64'(in_ready), 64'd1);
    chk("rstm_data", 64'({ovf, cout, sum}), 64'd0);
    tick();
    rst_n = 1'b1;
    run_vec(mk(32'd10, 32'd10, 1'b0, 1'b0, 32'd20, 1'b0, 1'b0), "after_rst");
    for (int i = 0; i < 4; i++) tick();
    chk("after_rst_count", 64'(got.size()), 64'd1);

    // Random traffic against the scoreboard.
    ndeliv = 0;
    for (int n = 0; n < 800; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a  = $urandom;
      b  = $urandom;
      c0 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
`ifdef CLA_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    chk("rand_drained", 64'(q.size()), 64'd0);
    chk("rand_activity", 64'(ndeliv > 200), 64'd1);

    // 16-bit builds: one stage versus four stages.
    r16 = 1'b1; v16 = 1'b1; a16 = 16'd20000; b16 = 16'd25555; c016 = 1'b0;
    tick();
    v16 = 1'b0;
    chk("s1_valid", 64'(ov1), 64'd1);
    chk("s1_result", 64'({of1, co1, s1}), 64'({1'b1, 1'b0, 16'd45555}));
    for (int i = 0; i < 3; i++) begin
      chk("s4_lat", 64'(ov4), 64'd0);
      tick();
    end
    chk("s4_valid", 64'(ov4), 64'd1);
    chk("s4_result", 64'({of4, co4, s4}), 64'({1'b1, 1'b0, 16'd45555}));
    tick();

    for (int i = 0; i < 43; i++) begin
      if (i < 40) begin
        a16 = 16'($urandom); b16 = 16'($urandom); c016 = 1'($urandom_range(0, 1));
        e16[i] = model16(a16, b16, c016);
        v16 = 1'b1;
      end else begin
        v16 = 1'b0;
      end
      #1;
      chk("s16_in_ready", 64'({ir1, ir4}), 64'd3);
      tick();
      if (i < 40) chk("s1_stream", 64'({ov1, of1, co1, s1}), 64'({1'b1, e16[i]}));
      if (i >= 3) chk("s4_stream", 64'({ov4, of4, co4, s4}), 64'({1'b1, e16[i-3]}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
